// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MIPS32 MULT/MULTU/DIV/DIVU engine for the execute stage.
// Produces the 64-bit {hi,lo} result. ok (hazard_intf.mult_ok) is high while a finished
// result is held; the hazard unit stalls F/D/E while it is low.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   valid           execute holds a mult/div instruction (held high during the stall)
//   op              00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b            rs / rt operands
//   advance         execute leaves E this cycle; releases a finished result
//   flush           abort the current op; hi/lo keep their previous value
//   hi, lo          DIV: remainder/quotient; MULT: product[63:32]/product[31:0]
//   ok              result valid
//
// Build option: define MULT_DSP_EN to compute multiplies with a '*' operator pipelined over
// MUL_STAGES registers (range 1..4). Without it, multiplies iterate shift-add over 32 cycles
// on the adder shared with the restoring divider. Divide is identical in both builds.
module mult_div_unit #(
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        advance,
  input  logic        flush,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        ok
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [5:0] DivLast = 6'd31;
`ifdef MULT_DSP_EN
  localparam bit         MulIter = 1'b0;
  localparam logic [5:0] MulLast = 6'(MUL_STAGES - 1);
`else
  localparam bit         MulIter = 1'b1;
  localparam logic [5:0] MulLast = 6'd31;
`endif

  if (MUL_STAGES == 0 || MUL_STAGES > 4) begin : g_bad_param
    $error("MUL_STAGES must be in 1..4");
  end

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        q_neg_q, q_neg_d;   // negate quotient / product
  logic        r_neg_q, r_neg_d;   // negate remainder
  logic [31:0] acc_hi_q, acc_hi_d; // partial remainder / product high half
  logic [31:0] acc_lo_q, acc_lo_d; // dividend->quotient / multiplier->product low half
  logic [31:0] opnd_q, opnd_d;     // divisor / multiplicand magnitude
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  // Operand magnitudes; signed ops negate in 32 bits, so 0x80000000 maps to 2^31 unsigned.
  logic        a_sgn, b_sgn;
  logic [31:0] a_mag, b_mag;
  assign a_sgn = ~op[0] & a[31];
  assign b_sgn = ~op[0] & b[31];
  assign a_mag = a_sgn ? (~a + 32'd1) : a;
  assign b_mag = b_sgn ? (~b + 32'd1) : b;

  // Shared adder: divide computes {rem,next bit} - divisor (bit 33 = no borrow),
  // multiply computes partial high half + multiplicand (bit 32 = carry).
  logic [32:0] add_x, add_y;
  logic        add_cin;
  logic [33:0] add_sum;
  always_comb begin
    if (is_div_q) begin
      add_x   = {acc_hi_q, acc_lo_q[31]};
      add_y   = ~{1'b0, opnd_q};
      add_cin = 1'b1;
    end else begin
      add_x   = {1'b0, acc_hi_q};
      add_y   = {1'b0, opnd_q};
      add_cin = 1'b0;
    end
  end
  assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {33'd0, add_cin};

  // One iteration of the restoring divider or the shift-add multiplier.
  logic        div_ge;
  logic [32:0] mul_sum;
  logic [31:0] step_hi, step_lo;
  always_comb begin
    div_ge  = add_sum[33];
    mul_sum = acc_lo_q[0] ? add_sum[32:0] : {1'b0, acc_hi_q};
    if (is_div_q) begin
      step_hi = div_ge ? add_sum[31:0] : add_x[31:0];
      step_lo = {acc_lo_q[30:0], div_ge};
    end else begin
      step_hi = mul_sum[32:1];
      step_lo = {mul_sum[0], acc_lo_q[31:1]};
    end
  end

  logic [63:0] mul_res;
`ifdef MULT_DSP_EN
  logic [63:0] mul_prod;
  assign mul_prod = {32'd0, opnd_q} * {32'd0, acc_lo_q};
  // The hi/lo register is the final stage, so only MUL_STAGES-1 pipe registers live here.
  if (MUL_STAGES == 1) begin : g_mul_direct
    assign mul_res = mul_prod;
  end else begin : g_mul_pipe
    logic [MUL_STAGES-2:0][63:0] pipe_q;
    always_ff @(posedge clk) begin
      pipe_q[0] <= mul_prod;
      for (int i = 1; i < int'(MUL_STAGES) - 1; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign mul_res = pipe_q[MUL_STAGES-2];
  end
`else
  assign mul_res = {step_hi, step_lo};
`endif

  // Sign fix applied as the final result is registered.
  logic [63:0] mul_fix;
  logic [31:0] quo_fix, rem_fix;
  logic        last;
  assign mul_fix = q_neg_q ? (~mul_res + 64'd1) : mul_res;
  assign quo_fix = q_neg_q ? (~step_lo + 32'd1) : step_lo;
  assign rem_fix = r_neg_q ? (~step_hi + 32'd1) : step_hi;
  assign last    = cnt_q == (is_div_q ? DivLast : MulLast);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      StIdle: begin
        if (valid) begin
          state_d  = StBusy;
          cnt_d    = 6'd0;
          is_div_d = op[1];
          // A zero divisor yields quotient all-ones for DIV too, so never negate it.
          q_neg_d  = (a_sgn ^ b_sgn) & (b != 32'd0);
          r_neg_d  = a_sgn;
          acc_hi_d = 32'd0;
          acc_lo_d = op[1] ? a_mag : b_mag;
          opnd_d   = op[1] ? b_mag : a_mag;
        end
      end
      StBusy: begin
        // In the DSP build the multiply operands must stay put for the '*' pipeline.
        if (is_div_q || MulIter) begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
        end
        cnt_d = cnt_q + 6'd1;
        if (last) begin
          state_d = StDone;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = mul_fix[63:32];
            lo_d = mul_fix[31:0];
          end
        end
      end
      StDone: begin
        if (advance) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d = StIdle;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 6'd0;
      is_div_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      acc_hi_q <= 32'd0;
      acc_lo_q <= 32'd0;
      opnd_q   <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;
  assign ok = (state_q == StDone);

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed vectors, a spec-level arithmetic model checked every
// cycle, and literal expectations pinning both the model and the DUT.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset, valid, advance, flush;
  logic [1:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        ok;

`ifdef MULT_DSP_EN
  localparam int MulLat = 3;
`else
  localparam int MulLat = 33;
`endif
  localparam int DivLat = 33;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  mult_div_unit #(.MUL_STAGES(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .valid   (valid),
    .op      (op),
    .a       (a),
    .b       (b),
    .advance (advance),
    .flush   (flush),
    .hi      (hi),
    .lo      (lo),
    .ok      (ok)
  );

  always #5 clk = ~clk;

  // Architectural result from plain arithmetic: {hi, lo}.
  function automatic logic [63:0] model_res(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    longint      sx, sy;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: r = 64'(sx * sy);
      2'd1: r = {32'd0, x} * {32'd0, y};
      2'd2: if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
            else r = {32'(sx % sy), 32'(sx / sy)};
      default: if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
               else r = {x % y, x / y};
    endcase
    return r;
  endfunction

  // Cycle-level view: start on valid when idle, result after a fixed latency, held until advance.
  bit          m_busy = 1'b0, m_done = 1'b0;
  int          m_cnt = 0, m_lat = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_res = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else if (flush) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end else if (m_done) begin
      if (advance) m_done <= 1'b0;
    end else if (m_busy) begin
      if (m_cnt == m_lat - 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_hi   <= m_res[63:32];
        m_lo   <= m_res[31:0];
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else if (valid) begin
      m_busy <= 1'b1;
      m_cnt  <= 1;
      m_res  <= model_res(op, a, b);
      m_lat  <= op[1] ? DivLat : MulLat;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if (ok !== m_done || hi !== m_hi || lo !== m_lo) begin
        n_bad++;
        $display("FAIL cycle t=%0t: got ok=%b hi=%h lo=%h, required ok=%b hi=%h lo=%h",
                 $time, ok, hi, lo, m_done, m_hi, m_lo);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ok(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ok && n < 100);
  endtask

  // Issue one op from IDLE, check latency and result, then release it with advance.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] req, input int lat);
    int n;
    op = o; a = x; b = y; valid = 1'b1;
    wait_ok(n);
    chk({name, " latency"}, 64'(n), 64'(lat));
    chk({name, " result"}, {hi, lo}, req);
    valid = 1'b0; advance = 1'b1;
    tick();
    advance = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] saved;
    int          n;
    reset = 1'b1; valid = 1'b0; advance = 1'b0; flush = 1'b0;
    op = 2'd0; a = '0; b = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("reset ok", 64'(ok), 64'd0);
    chk("reset hilo", {hi, lo}, 64'd0);
    chk_en = 1'b1;

    // Pin the model with hand-computed values.
    chk("model multu", model_res(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    chk("model mult", model_res(2'd0, 32'hFFFF_FFFD, 32'd5), 64'hFFFF_FFFF_FFFF_FFF1);
    chk("model div", model_res(2'd2, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    chk("model divu0", model_res(2'd3, 32'h1234, 32'd0), 64'h0000_1234_FFFF_FFFF);
    chk("model divmin", model_res(2'd2, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
    chk("model divu", model_res(2'd3, 32'd100, 32'd7), 64'h0000_0002_0000_000E);

    run_op("multu max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, MulLat);
    run_op("mult -3*5", 2'd0, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, MulLat);
    run_op("div -7/2", 2'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, DivLat);
    run_op("divu by0", 2'd3, 32'h1234, 32'd0, 64'h0000_1234_FFFF_FFFF, DivLat);
    run_op("div min/-1", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, DivLat);
    run_op("div neg by0", 2'd2, 32'hFFFF_FFF0, 32'd0, 64'hFFFF_FFF0_FFFF_FFFF, DivLat);
    run_op("div 100/-7", 2'd2, 32'd100, 32'hFFFF_FFF9, model_res(2'd2, 32'd100, 32'hFFFF_FFF9),
           DivLat);
    run_op("div -100/-7", 2'd2, 32'hFFFF_FF9C, 32'hFFFF_FFF9,
           model_res(2'd2, 32'hFFFF_FF9C, 32'hFFFF_FFF9), DivLat);
    run_op("divu 5/9", 2'd3, 32'd5, 32'd9, 64'h0000_0005_0000_0000, DivLat);
    run_op("divu max/1", 2'd3, 32'hFFFF_FFFF, 32'd1, 64'h0000_0000_FFFF_FFFF, DivLat);
    run_op("mult min*min", 2'd0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, MulLat);
    run_op("multu mix", 2'd1, 32'h1234_5678, 32'h9ABC_DEF0,
           model_res(2'd1, 32'h1234_5678, 32'h9ABC_DEF0), MulLat);

    // Flush at cycle 10 of a DIVU: no result, hi/lo unchanged.
    saved = {hi, lo};
    op = 2'd3; a = 32'd100; b = 32'd7; valid = 1'b1;
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; valid = 1'b0;
    chk("flush ok", 64'(ok), 64'd0);
    chk("flush hilo", {hi, lo}, saved);
    run_op("divu after flush", 2'd3, 32'd100, 32'd7, 64'h0000_0002_0000_000E, DivLat);

    // Flush beats valid in IDLE: nothing may start.
    valid = 1'b1; flush = 1'b1;
    tick();
    valid = 1'b0; flush = 1'b0;
    repeat (40) tick();
    chk("idle flush no start", 64'(ok), 64'd0);

    // Hold in DONE for 5 cycles with valid toggling, then advance with valid high.
    op = 2'd3; a = 32'd100; b = 32'd7; valid = 1'b1;
    wait_ok(n);
    chk("hold latency", 64'(n), 64'(DivLat));
    saved = {hi, lo};
    chk("hold result", saved, 64'h0000_0002_0000_000E);
    for (int i = 0; i < 5; i++) begin
      valid = i[0]; op = i[1:0]; a = $urandom; b = $urandom;
      tick();
      chk("hold ok", 64'(ok), 64'd1);
      chk("hold hilo", {hi, lo}, saved);
    end
    op = 2'd3; a = 32'd100; b = 32'd7; valid = 1'b1; advance = 1'b1;
    tick();
    advance = 1'b0;
    chk("advance ok drop", 64'(ok), 64'd0);
    wait_ok(n);
    chk("restart latency", 64'(n), 64'(DivLat));
    chk("restart result", {hi, lo}, 64'h0000_0002_0000_000E);
    valid = 1'b0; advance = 1'b1;
    tick();
    advance = 1'b0;

    // Reset mid-op clears hi/lo.
    op = 2'd2; a = 32'hFFFF_FFF9; b = 32'd2; valid = 1'b1;
    repeat (5) tick();
    reset = 1'b1; valid = 1'b0;
    tick();
    reset = 1'b0;
    chk("midreset ok", 64'(ok), 64'd0);
    chk("midreset hilo", {hi, lo}, 64'd0);
    run_op("mult after reset", 2'd0, 32'd7, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9, MulLat);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
